alu_op_sequencer: RTL

Multi-cycle command sequencer in front of the combinational 32-bit ALU built from `alu_1bit` slices. Accepts one command at a time on a valid/ready port, drives the ALU's A/B/Cin/sel inputs from registers, and captures F/Cout into a response register with zero/negative flags. Multi-bit shifts are built by iterating the ALU's single-bit shift ops, feeding `alu_f` back into `alu_a` once per cycle.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_op_sequencer_if.sv | 55 +++++
 rtl/alu_seq_flags.sv | 27 ++
 rtl/alu_op_sequencer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: select groups, FSM states,
// default widths and the effective-B helper used for overflow detection.
package alu_pkg;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_SHAMT_W = 5;

  localparam logic [1:0] SEL_ARITH = 2'b00;
  localparam logic [1:0] SEL_LOGIC = 2'b01;
  localparam logic [1:0] SEL_SHR   = 2'b10;
  localparam logic [1:0] SEL_SHL   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // MSB of the ALU's effective B operand (0 / b / ~b / all-ones) for an arith sub-op.
  function automatic logic bvar_msb(input logic [1:0] sub_op, input logic b_msb);
    case (sub_op)
      2'b00:   return 1'b0;
      2'b01:   return b_msb;
      2'b10:   return ~b_msb;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command, ALU-drive and response signals of alu_op_sequencer.
// rsp_ovf exists only when ALU_SEQ_OVF_EN is defined.
interface alu_op_sequencer_if
  import alu_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int SHAMT_W = DEFAULT_SHAMT_W
);

  logic               cmd_valid;
  logic               cmd_ready;
  logic [3:0]         cmd_sel;
  logic [WIDTH-1:0]   cmd_a;
  logic [WIDTH-1:0]   cmd_b;
  logic               cmd_cin;
  logic [SHAMT_W-1:0] cmd_shamt;

  logic [WIDTH-1:0]   alu_a;
  logic [WIDTH-1:0]   alu_b;
  logic               alu_cin;
  logic [3:0]         alu_sel;
  logic [WIDTH-1:0]   alu_f;
  logic               alu_cout;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [WIDTH-1:0]   rsp_f;
  logic               rsp_cout;
  logic               rsp_zero;
  logic               rsp_neg;
`ifdef ALU_SEQ_OVF_EN
  logic               rsp_ovf;
`endif

  modport slave (
    input  cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_cin, cmd_shamt,
    input  alu_f, alu_cout, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_cin, alu_sel,
    output rsp_valid, rsp_f, rsp_cout, rsp_zero, rsp_neg
`ifdef ALU_SEQ_OVF_EN
    , output rsp_ovf
`endif
  );

  modport master (
    output cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_cin, cmd_shamt,
    output alu_f, alu_cout, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_cin, alu_sel,
    input  rsp_valid, rsp_f, rsp_cout, rsp_zero, rsp_neg
`ifdef ALU_SEQ_OVF_EN
    , input rsp_ovf
`endif
  );

endinterface

// File: rtl/alu_seq_flags.sv
// Zero/negative (and, with ALU_SEQ_OVF_EN, signed-overflow) flags for the value
// about to be captured into the response register.
module alu_seq_flags
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] f_i,
`ifdef ALU_SEQ_OVF_EN
  input  logic             a_msb_i,
  input  logic             bvar_msb_i,
  input  logic [1:0]       grp_i,
  output logic             ovf_o,
`endif
  output logic             zero_o,
  output logic             neg_o
);

  assign zero_o = (f_i == '0);
  assign neg_o  = f_i[WIDTH-1];

`ifdef ALU_SEQ_OVF_EN
  // Operands of equal sign producing a result of the other sign.
  assign ovf_o = (grp_i == SEL_ARITH) && (a_msb_i == bvar_msb_i) && (f_i[WIDTH-1] != a_msb_i);
`endif

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle command sequencer driving an external combinational ALU; multi-bit
// shifts iterate the ALU's 1-bit shift. Optional feature macro: ALU_SEQ_OVF_EN.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int SHAMT_W = DEFAULT_SHAMT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_op_sequencer_if.slave  bus
);

  state_e             state_q, state_d;
  logic               ready_q;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               cin_q, cin_d;
  logic [3:0]         sel_q, sel_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   f_q, f_d;
  logic               cout_q, cout_d;
  logic               zero_q, neg_q;
  logic               zero_c, neg_c;
  logic               cap;
`ifdef ALU_SEQ_OVF_EN
  logic               ovf_c, ovf_q;
`endif

  // NOTE: every always_comb output gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    f_d     = f_q;
    cout_d  = cout_q;
    cap     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ready_q && bus.cmd_valid) begin
          a_d     = bus.cmd_a;
          b_d     = bus.cmd_b;
          cin_d   = bus.cmd_cin;
          sel_d   = bus.cmd_sel;
          cnt_d   = bus.cmd_shamt;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (!sel_q[3]) begin
          f_d     = bus.alu_f;
          cout_d  = (sel_q[3:2] == SEL_ARITH) ? bus.alu_cout : 1'b0;
          cap     = 1'b1;
          state_d = ST_RESP;
        end else if (cnt_q == '0) begin
          f_d     = a_q;
          cout_d  = 1'b0;
          cap     = 1'b1;
          state_d = ST_RESP;
        end else begin
          // One ALU shift per cycle; the bit leaving alu_a becomes the carry.
          a_d    = bus.alu_f;
          cout_d = (sel_q[3:2] == SEL_SHR) ? a_q[0] : a_q[WIDTH-1];
          cnt_d  = cnt_q - SHAMT_W'(1);
          if (cnt_q == SHAMT_W'(1)) begin
            f_d     = bus.alu_f;
            cap     = 1'b1;
            state_d = ST_RESP;
          end
        end
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          a_d     = '0;
          b_d     = '0;
          cin_d   = 1'b0;
          sel_d   = 4'b0000;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  alu_seq_flags #(.WIDTH(WIDTH)) u_flags (
    .f_i        (f_d),
`ifdef ALU_SEQ_OVF_EN
    .a_msb_i    (a_q[WIDTH-1]),
    .bvar_msb_i (bvar_msb(sel_q[1:0], b_q[WIDTH-1])),
    .grp_i      (sel_q[3:2]),
    .ovf_o      (ovf_c),
`endif
    .zero_o     (zero_c),
    .neg_o      (neg_c)
  );

  // NOTE: the datapath registers are reset as well as the FSM, because every
  // output (ALU drive and response) must read 0 while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      sel_q   <= 4'b0000;
      cnt_q   <= '0;
      f_q     <= '0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      ready_q <= (state_d == ST_IDLE);
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
      cout_q  <= cout_d;
      if (cap) begin
        zero_q <= zero_c;
        neg_q  <= neg_c;
      end
    end
  end

`ifdef ALU_SEQ_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (cap) begin
      ovf_q <= ovf_c;
    end
  end

  assign bus.rsp_ovf = ovf_q;
`endif

  assign bus.cmd_ready = ready_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_cin   = cin_q;
  assign bus.alu_sel   = sel_q;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_f     = f_q;
  assign bus.rsp_cout  = cout_q;
  assign bus.rsp_zero  = zero_q;
  assign bus.rsp_neg   = neg_q;

endmodule
